axis_rr_arb_2_1: RTL and testbench

AXIS_RR_ARB_2_1 -- requirements
Module: axis_rr_arb_2_1

---
 rtl/axis_rr_arb_2_1.sv | 132 +++++++++++++
 tb/tb_axis_rr_arb_2_1.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arb_2_1.sv
// ---------------------------------------------------------------------------
// axis_rr_arb_2_1
// Two-input AXI-Stream packet arbiter with round-robin fairness.
//
// Whole packets are forwarded from one slave port at a time. The grant moves
// only in IDLE, after a beat with tlast has been accepted, so there is always
// one bubble cycle between packets. When both ports are waiting in IDLE, the
// port that was not served last gets the grant.
// Slave beats pass through a single output register with 1-cycle latency.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   s1_* / s2_*     AXI-Stream slave ports (tdata, tvalid, tlast in; tready out)
//   m_*             AXI-Stream master port (tdata, tvalid, tlast registered out;
//                   tready in)
//   gnt             one-hot current grant (bit0 = s1, bit1 = s2), 2'b00 = idle
// ---------------------------------------------------------------------------
module axis_rr_arb_2_1 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s1_tdata,
  input  logic          s1_tvalid,
  input  logic          s1_tlast,
  output logic          s1_tready,
  input  logic [DW-1:0] s2_tdata,
  input  logic          s2_tvalid,
  input  logic          s2_tlast,
  output logic          s2_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_S1 = 2'b01,
    GNT_S2 = 2'b10
  } state_t;

  state_t state;
  // 1'b1 = s2 was served last, 1'b0 = s1 was served last.
  logic   last_served;

  logic   out_free;
  logic   s1_acc;
  logic   s2_acc;

  // The output register can take a new beat when empty or being drained.
  assign out_free  = !m_tvalid || m_tready;

  // Readies are gated by rst so nothing is accepted during reset.
  assign s1_tready = !rst && (state == GNT_S1) && out_free;
  assign s2_tready = !rst && (state == GNT_S2) && out_free;

  assign s1_acc    = s1_tvalid && s1_tready;
  assign s2_acc    = s2_tvalid && s2_tready;

  // Arbitration FSM, grant register and output beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      gnt         <= 2'b00;
      m_tdata     <= {DW{1'b0}};
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
    end else begin
      // Output register: load accepted beat, else drain, else hold.
      if (s1_acc) begin
        m_tdata  <= s1_tdata;
        m_tvalid <= 1'b1;
        m_tlast  <= s1_tlast;
      end else if (s2_acc) begin
        m_tdata  <= s2_tdata;
        m_tvalid <= 1'b1;
        m_tlast  <= s2_tlast;
      end else if (m_tready) begin
        // m_tdata deliberately keeps the last beat.
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end else begin
        m_tvalid <= m_tvalid;
        m_tlast  <= m_tlast;
      end

      case (state)
        IDLE: begin
          // s1 wins when alone, or in contention if s2 was served last.
          if (s1_tvalid && (!s2_tvalid || last_served)) begin
            state <= GNT_S1;
            gnt   <= 2'b01;
          end else if (s2_tvalid) begin
            state <= GNT_S2;
            gnt   <= 2'b10;
          end else begin
            state <= IDLE;
            gnt   <= 2'b00;
          end
        end
        GNT_S1: begin
          if (s1_acc && s1_tlast) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            last_served <= 1'b0;
          end else begin
            state <= GNT_S1;
            gnt   <= 2'b01;
          end
        end
        GNT_S2: begin
          if (s2_acc && s2_tlast) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            last_served <= 1'b1;
          end else begin
            state <= GNT_S2;
            gnt   <= 2'b10;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arb_2_1.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arb_2_1
// Bench for axis_rr_arb_2_1: directed packet scenarios with literal
// expectations on the forwarded beat order, followed by a randomized phase.
// A behavioural model (grant owner, preferred port, one output beat) predicts
// every DUT output each cycle.
// ---------------------------------------------------------------------------
module tb_axis_rr_arb_2_1;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s1_tdata, s2_tdata, m_tdata;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          s2_tvalid, s2_tlast, s2_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    gnt;

  axis_rr_arb_2_1 #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(s2_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .gnt(gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         mg    = 0;   // port owning the grant: 0 none, 1 s1, 2 s2
  int         mpref = 1;   // port that wins the next contention
  bit         mv    = 1'b0;
  bit [DW-1:0] md   = '0;
  bit         ml    = 1'b0;

  function automatic bit exp_ready(input int port);
    return !rst && (mg == port) && (!mv || m_tready);
  endfunction

  // Model advances on each rising edge from the (stable) bench-driven inputs.
  always @(posedge clk) begin
    int acc;
    bit lst;
    if (rst) begin
      mg = 0; mpref = 1; mv = 1'b0; md = '0; ml = 1'b0;
    end else begin
      acc = 0;
      if (exp_ready(1) && s1_tvalid) acc = 1;
      if (exp_ready(2) && s2_tvalid) acc = 2;
      lst = (acc == 1) ? s1_tlast : s2_tlast;
      if (acc != 0) begin
        md = (acc == 1) ? s1_tdata : s2_tdata;
        mv = 1'b1;
        ml = lst;
      end else if (m_tready) begin
        mv = 1'b0;
      end
      if (mg == 0) begin
        if (s1_tvalid && s2_tvalid) mg = mpref;
        else if (s1_tvalid)         mg = 1;
        else if (s2_tvalid)         mg = 2;
      end else if (acc != 0 && lst) begin
        mpref = (mg == 1) ? 2 : 1;
        mg    = 0;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, mv});
    chk("m_tdata", {24'd0, m_tdata}, {24'd0, md});
    if (mv) chk("m_tlast", {31'd0, m_tlast}, {31'd0, ml});
    chk("gnt", {30'd0, gnt}, (mg == 1) ? 32'd1 : (mg == 2) ? 32'd2 : 32'd0);
    chk("s1_tready", {31'd0, s1_tready}, {31'd0, exp_ready(1)});
    chk("s2_tready", {31'd0, s2_tready}, {31'd0, exp_ready(2)});
  end

  // Monitor: beats handed downstream (beats pending at a reset edge are discarded).
  logic [DW:0] out_log[$];
  logic [DW:0] exp_log[$];
  int out_cnt = 0;
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      out_log.push_back({m_tlast, m_tdata});
      out_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  logic [DW:0] q1[$], q2[$];
  int vp1 = 100, vp2 = 100;
  int gap1 = 0, gap2 = 0, gapreq1 = 0, gapreq2 = 0;
  bit rand_mr = 1'b0;
  int mr_pct = 100;
  bit acc1, acc2;
  int in_cnt = 0;

  task automatic drive_upd(input bit a1, input bit a2);
    if (a1) void'(q1.pop_front());
    if (a1 && gapreq1 > 0) begin gap1 = gapreq1; gapreq1 = 0; end
    if (q1.size() == 0) s1_tvalid = 1'b0;
    else if (!(s1_tvalid && !a1)) begin
      if (gap1 > 0) begin s1_tvalid = 1'b0; gap1--; end
      else s1_tvalid = ($urandom_range(99) < vp1);
    end
    if (q1.size() != 0) {s1_tlast, s1_tdata} = q1[0];

    if (a2) void'(q2.pop_front());
    if (a2 && gapreq2 > 0) begin gap2 = gapreq2; gapreq2 = 0; end
    if (q2.size() == 0) s2_tvalid = 1'b0;
    else if (!(s2_tvalid && !a2)) begin
      if (gap2 > 0) begin s2_tvalid = 1'b0; gap2--; end
      else s2_tvalid = ($urandom_range(99) < vp2);
    end
    if (q2.size() != 0) {s2_tlast, s2_tdata} = q2[0];
  endtask

  // One clock: sample handshakes at the falling edge, update drivers after the rise.
  task automatic step();
    @(negedge clk);
    acc1 = s1_tvalid && s1_tready;
    acc2 = s2_tvalid && s2_tready;
    if (acc1 || acc2) in_cnt++;
    @(posedge clk);
    #1;
    if (rand_mr) m_tready = ($urandom_range(99) < mr_pct);
    drive_upd(acc1, acc2);
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || m_tvalid) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, {31'd0, (n >= budget)}, 32'd0);
    step();
    step();
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, out_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), {23'd0, out_log[i]}, {23'd0, exp_log[i]});
    out_log.delete();
    exp_log.delete();
  endtask

  task automatic push_pkt(input int port);
    int len = $urandom_range(4, 1);
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      if (port == 1) q1.push_back({(i == len - 1), d});
      else           q2.push_back({(i == len - 1), d});
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; m_tready = 1'b1;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    s2_tvalid = 1'b0; s2_tlast = 1'b0; s2_tdata = '0;
    repeat (3) step();
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);

    // Both ports valid out of reset: s1 first, then s2.
    q1.push_back({1'b0, 8'h11}); q1.push_back({1'b1, 8'h12});
    q2.push_back({1'b0, 8'h21}); q2.push_back({1'b1, 8'h22});
    drive_upd(1'b0, 1'b0);
    step();
    chk("rst_s1_tready", {31'd0, s1_tready}, 32'd0);
    rst = 1'b0;
    step();
    chk("first_gnt", {30'd0, gnt}, 32'h1);
    chk("first_s1_tready", {31'd0, s1_tready}, 32'd1);
    run_until_empty("contend1", 200);
    exp_log = '{9'h011, 9'h112, 9'h021, 9'h122};
    check_log("contend1");

    // Immediate repeat: s1 preferred again.
    q1.push_back({1'b0, 8'h11}); q1.push_back({1'b1, 8'h12});
    q2.push_back({1'b0, 8'h21}); q2.push_back({1'b1, 8'h22});
    drive_upd(1'b0, 1'b0);
    run_until_empty("contend2", 200);
    exp_log = '{9'h011, 9'h112, 9'h021, 9'h122};
    check_log("contend2");

    // s1 alone, then contention: s2 wins.
    q1.push_back({1'b1, 8'h51});
    drive_upd(1'b0, 1'b0);
    run_until_empty("s1_alone", 200);
    q1.push_back({1'b1, 8'h61});
    q2.push_back({1'b1, 8'h71});
    drive_upd(1'b0, 1'b0);
    run_until_empty("contend3", 200);
    exp_log = '{9'h151, 9'h171, 9'h161};
    check_log("contend3");

    // Three-beat s1 packet.
    q1.push_back({1'b0, 8'hA1}); q1.push_back({1'b0, 8'hA2}); q1.push_back({1'b1, 8'hA3});
    drive_upd(1'b0, 1'b0);
    step();
    chk("pkt3_gnt", {30'd0, gnt}, 32'h1);
    chk("pkt3_s2_tready", {31'd0, s2_tready}, 32'd0);
    step();
    chk("pkt3_first_data", {24'd0, m_tdata}, 32'hA1);
    chk("pkt3_first_valid", {31'd0, m_tvalid}, 32'd1);
    run_until_empty("pkt3", 200);
    exp_log = '{9'h0A1, 9'h0A2, 9'h1A3};
    check_log("pkt3");
    chk("pkt3_gnt_end", {30'd0, gnt}, 32'd0);

    // Backpressure while 0x12 sits in the output register.
    q1.push_back({1'b0, 8'h11}); q1.push_back({1'b0, 8'h12}); q1.push_back({1'b1, 8'h13});
    drive_upd(1'b0, 1'b0);
    n = 0;
    while (!(m_tvalid && m_tdata == 8'h12) && n < 20) begin step(); n++; end
    chk("bp_reach_timeout", {31'd0, (n >= 20)}, 32'd0);
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_data", {24'd0, m_tdata}, 32'h12);
      chk("bp_hold_valid", {31'd0, m_tvalid}, 32'd1);
      chk("bp_s1_tready", {31'd0, s1_tready}, 32'd0);
      step();
    end
    m_tready = 1'b1;
    run_until_empty("bp", 200);
    exp_log = '{9'h011, 9'h012, 9'h113};
    check_log("bp");

    // s2 drops valid mid-packet while s1 waits (last served s1, so s2 wins).
    q2.push_back({1'b0, 8'h81}); q2.push_back({1'b0, 8'h82}); q2.push_back({1'b1, 8'h83});
    q1.push_back({1'b0, 8'h91}); q1.push_back({1'b1, 8'h92});
    gapreq2 = 2;
    drive_upd(1'b0, 1'b0);
    n = 0;
    while (!acc2 && n < 20) begin step(); n++; end
    chk("gap_reach_timeout", {31'd0, (n >= 20)}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("gap_s2_tvalid", {31'd0, s2_tvalid}, 32'd0);
      chk("gap_gnt", {30'd0, gnt}, 32'h2);
      chk("gap_s1_tready", {31'd0, s1_tready}, 32'd0);
      step();
    end
    run_until_empty("gap", 200);
    exp_log = '{9'h081, 9'h082, 9'h183, 9'h091, 9'h192};
    check_log("gap");

    // Reset after the first beat of a 4-beat s2 packet, s1 pending.
    q2.push_back({1'b0, 8'h31}); q2.push_back({1'b0, 8'h32});
    q2.push_back({1'b0, 8'h33}); q2.push_back({1'b1, 8'h34});
    drive_upd(1'b0, 1'b0);
    step();
    chk("rstmid_gnt_s2", {30'd0, gnt}, 32'h2);
    q1.push_back({1'b0, 8'h41}); q1.push_back({1'b1, 8'h42});
    drive_upd(1'b0, 1'b0);
    n = 0;
    acc2 = 1'b0;
    while (!acc2 && n < 20) begin step(); n++; end
    chk("rstmid_reach_timeout", {31'd0, (n >= 20)}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rstmid_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rstmid_m_tdata", {24'd0, m_tdata}, 32'd0);
    chk("rstmid_m_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rstmid_gnt", {30'd0, gnt}, 32'd0);
    step();
    chk("rstmid_regrant", {30'd0, gnt}, 32'h1);
    run_until_empty("rstmid", 200);
    exp_log = '{9'h041, 9'h142, 9'h032, 9'h033, 9'h134};
    check_log("rstmid");

    // Randomized traffic, valid gaps and backpressure.
    in_cnt = 0; out_cnt = 0;
    rand_mr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        vp1 = $urandom_range(100, 30);
        vp2 = $urandom_range(100, 30);
        mr_pct = $urandom_range(100, 40);
      end
      if (q1.size() == 0 && $urandom_range(3) == 0) push_pkt(1);
      if (q2.size() == 0 && $urandom_range(3) == 0) push_pkt(2);
      step();
    end
    rand_mr = 1'b0;
    m_tready = 1'b1;
    vp1 = 100; vp2 = 100;
    run_until_empty("random", 2000);
    chk("random_beat_count", out_cnt, in_cnt);
    out_log.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
